id_inst_queue: RTL and testbench

//  Parametrised instruction queue between IF and ID: buffers {pc, inst} pairs from the

---
 rtl/id_inst_queue_pkg.sv | 20 ++
 rtl/id_inst_queue_regarray.sv | 49 ++++
 rtl/id_inst_queue.sv | 136 +++++++++++++
 tb/tb_id_inst_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg
//   Shared definitions for the IF->ID instruction queue.
//   - flush_kind_e : classification of a flush cycle, used by the queue control
//   - iq_entry_wd  : width of one stored entry; entries are packed {pc, inst}
package id_inst_queue_pkg;

   // How a flush is resolved in the cycle the branch leaves the head.
   typedef enum logic [1:0] {
      FLUSH_NONE        = 2'd0,  // no flush, or flush without a deq (ignored)
      FLUSH_KEEP_BEHIND = 2'd1,  // entry behind the head is the delay slot; rest dropped
      FLUSH_KEEP_ENQ    = 2'd2,  // head was the only entry; this cycle's enq is the slot
      FLUSH_TO_EMPTY    = 2'd3   // head was the only entry; slot still to arrive
   } flush_kind_e;

   // Entry packing order is {pc, inst}: pc in the upper bits.
   function automatic int iq_entry_wd(input int pc_w, input int inst_w);
      return pc_w + inst_w;
   endfunction

endpackage

// File: rtl/id_inst_queue_regarray.sv
// iq_regarray
//   DEPTH x WIDTH flop storage with one synchronous write port and one
//   asynchronous read port. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : contents of slot raddr (combinational)
module iq_regarray
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] entries [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_d;
         logic [WIDTH-1:0] entry_q;

         always_comb begin
            entry_d = entry_q;
            if (we && (waddr == AW'(gi)))
               entry_d = wdata;
         end

         always_ff @(posedge clk) begin
            entry_q <= entry_d;
         end

         assign entries[gi] = entry_q;
      end
   endgenerate

   assign rdata = entries[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// id_inst_queue
//   Instruction queue between IF and ID. Buffers {pc, inst} pairs so a stalled
//   decode stage never loses an instruction; decode reads the head directly.
//   A taken branch (flush, asserted while the branch dequeues) discards
//   wrong-path entries but keeps the delay slot. Discarded entries are counted
//   in a saturating counter.
//   clk, resetn          : clock, synchronous active-low reset
//   enq_valid/ready/pc/inst : IF side (enq_ready = !full)
//   deq_valid/ready/pc/inst : ID side (head entry, combinational from storage)
//   flush                : branch taken; only honoured when deq fires
//   count                : occupancy
//   drop_cnt             : saturating count of flushed entries
module id_inst_queue
   import id_inst_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [PC_W-1:0]          enq_pc,
   input  logic [INST_W-1:0]        enq_inst,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [PC_W-1:0]          deq_pc,
   output logic [INST_W-1:0]        deq_inst,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = iq_entry_wd(PC_W, INST_W);

   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             slot_pending_q, slot_pending_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic             enq_fire, deq_fire;
   flush_kind_e      flush_kind;
   logic [CW-1:0]    drop_amt;
   logic [CNT_W:0]   drop_sum;
   logic [EW-1:0]    head_entry;

   // Full/empty come from the occupancy count, never from pointer compare.
   assign enq_ready = (count_q != CW'(DEPTH));
   assign deq_valid = (count_q != '0);
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;

   always_comb begin
      flush_kind = FLUSH_NONE;
      if (flush && deq_fire) begin
         if (count_q >= CW'(2))
            flush_kind = FLUSH_KEEP_BEHIND;
         else if (enq_fire)
            flush_kind = FLUSH_KEEP_ENQ;
         else
            flush_kind = FLUSH_TO_EMPTY;
      end
   end

   always_comb begin
      rd_ptr_d       = rd_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      slot_pending_d = slot_pending_q;
      drop_amt       = '0;

      if (flush_kind == FLUSH_KEEP_BEHIND) begin
         // Keep only the entry right behind the branch; rewind the write
         // pointer to just past it so anything further back (including an
         // enq accepted this cycle) is forgotten.
         rd_ptr_d = rd_ptr_q + AW'(1);
         wr_ptr_d = rd_ptr_q + AW'(2);
         count_d  = CW'(1);
         drop_amt = count_q - CW'(2) + CW'(enq_fire);
      end else begin
         // KEEP_ENQ and TO_EMPTY behave as an ordinary deq (plus enq).
         if (enq_fire)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq_fire)
            rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
      end

      if (flush_kind == FLUSH_TO_EMPTY)
         slot_pending_d = 1'b1;
      else if (enq_fire)
         slot_pending_d = 1'b0;

      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_amt);
      drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         slot_pending_q <= 1'b0;
         drop_cnt_q     <= '0;
      end else begin
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         slot_pending_q <= slot_pending_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end

   iq_regarray #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_regarray (
      .clk   (clk),
      .we    (enq_fire),
      .waddr (wr_ptr_q),
      .wdata ({enq_pc, enq_inst}),
      .raddr (rd_ptr_q),
      .rdata (head_entry)
   );

   assign deq_pc   = head_entry[EW-1:INST_W];
   assign deq_inst = head_entry[INST_W-1:0];
   assign count    = count_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_id_inst_queue.sv
module tb_id_inst_queue;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int CNT_W  = 4;   // narrow so saturation is reachable quickly
   localparam int SAT    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              resetn;
   logic              enq_valid;
   logic              enq_ready;
   logic [PC_W-1:0]   enq_pc;
   logic [INST_W-1:0] enq_inst;
   logic              deq_valid;
   logic              deq_ready;
   logic [PC_W-1:0]   deq_pc;
   logic [INST_W-1:0] deq_inst;
   logic              flush;
   logic [2:0]        count;
   logic [CNT_W-1:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t mq[$];      // reference queue contents, head at index 0
   int   m_drop;     // reference drop counter

   always #5 clk = ~clk;

   id_inst_queue #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INST_W (INST_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_pc    (enq_pc),
      .enq_inst  (enq_inst),
      .deq_valid (deq_valid),
      .deq_ready (deq_ready),
      .deq_pc    (deq_pc),
      .deq_inst  (deq_inst),
      .flush     (flush),
      .count     (count),
      .drop_cnt  (drop_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare all visible state against the reference model.
   task automatic chk_state(input string tag);
      check({tag, ".count"}, 64'(count), 64'(mq.size()));
      check({tag, ".enq_ready"}, 64'(enq_ready), 64'(mq.size() < DEPTH));
      check({tag, ".deq_valid"}, 64'(deq_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         check({tag, ".deq_pc"}, 64'(deq_pc), 64'(mq[0].pc));
         check({tag, ".deq_inst"}, 64'(deq_inst), 64'(mq[0].inst));
      end
      check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
   endtask

   // One clock cycle: drive at negedge, model the edge, check at next negedge.
   task automatic step(input string tag, input bit ev, input bit dr, input bit fl,
                       input logic [31:0] pc, input logic [31:0] inst);
      bit   e_f, d_f;
      int   drop;
      ent_t k;
      enq_valid = ev;
      deq_ready = dr;
      flush     = fl;
      enq_pc    = pc;
      enq_inst  = inst;
      e_f = ev && (mq.size() < DEPTH);
      d_f = dr && (mq.size() > 0);
      @(posedge clk);
      if (fl && d_f) begin
         void'(mq.pop_front());
         if (mq.size() >= 1) begin
            // everything past the delay slot, plus any enq this cycle, is lost
            drop = mq.size() - 1 + int'(e_f);
            k = mq[0];
            mq.delete();
            mq.push_back(k);
         end else begin
            drop = 0;
            if (e_f) mq.push_back('{pc, inst});
         end
         m_drop = (m_drop + drop > SAT) ? SAT : m_drop + drop;
      end else begin
         if (d_f) void'(mq.pop_front());
         if (e_f) mq.push_back('{pc, inst});
      end
      @(negedge clk);
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      flush     = 1'b0;
      chk_state(tag);
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      flush     = 1'b0;
      @(posedge clk);
      mq.delete();
      m_drop = 0;
      @(negedge clk);
      resetn = 1'b1;
      chk_state("reset");
   endtask

   initial begin
      bit ev, dr, fl;
      resetn = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
      enq_pc = '0; enq_inst = '0; m_drop = 0;
      @(negedge clk);
      do_reset();
      check("reset.count_zero", 64'(count), 64'd0);
      check("reset.enq_ready", 64'(enq_ready), 64'd1);

      // Fill with boot-vector pcs; head shows up one cycle after the first enq.
      step("fill0", 1, 0, 0, 32'hBFC00000, 32'h1000_0000);
      check("fill.first_pc", 64'(deq_pc), 64'h0BFC00000);
      for (int k = 1; k < 4; k++)
         step("fill", 1, 0, 0, 32'hBFC00000 + 32'(4 * k), 32'h1000_0000 + 32'(k));
      check("full.count", 64'(count), 64'd4);
      check("full.enq_ready", 64'(enq_ready), 64'd0);

      // Full with enq+deq requested: only the deq fires.
      step("full_both", 1, 1, 0, 32'hBFC00010, 32'h1000_0004);
      check("full_both.count", 64'(count), 64'd3);
      step("refill", 1, 0, 0, 32'hBFC00010, 32'h1000_0004);
      check("refill.count", 64'(count), 64'd4);

      // Flush without a deq is ignored.
      step("flush_nodeq", 0, 0, 1, 32'h0, 32'h0);
      check("flush_nodeq.count", 64'(count), 64'd4);
      for (int k = 0; k < 4; k++) step("drain", 0, 1, 0, 32'h0, 32'h0);

      // Flush at 0x100 with three entries behind it: keep 0x104, drop 2.
      for (int k = 0; k < 4; k++)
         step("q100", 1, 0, 0, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k));
      step("flush100", 0, 1, 1, 32'h0, 32'h0);
      check("flush100.deq_pc", 64'(deq_pc), 64'h104);
      check("flush100.count", 64'(count), 64'd1);
      check("flush100.drop", 64'(drop_cnt), 64'd2);
      step("drain104", 0, 1, 0, 32'h0, 32'h0);

      // Lone branch flushed with no enq: delay slot arrives later and is kept.
      step("q200", 1, 0, 0, 32'h200, 32'hB000);
      step("flush200", 0, 1, 1, 32'h0, 32'h0);
      check("flush200.deq_valid", 64'(deq_valid), 64'd0);
      step("slot204", 1, 0, 0, 32'h204, 32'hB001);
      step("next300", 1, 0, 0, 32'h300, 32'hB002);
      check("slot.count", 64'(count), 64'd2);
      check("slot.deq_pc", 64'(deq_pc), 64'h204);
      check("slot.drop", 64'(drop_cnt), 64'd2);
      step("drain", 0, 1, 0, 32'h0, 32'h0);
      step("drain", 0, 1, 0, 32'h0, 32'h0);

      // Lone branch flushed while its delay slot enqueues in the same cycle.
      step("q400", 1, 0, 0, 32'h400, 32'hC000);
      step("flush400", 1, 1, 1, 32'h404, 32'hC001);
      check("flush400.deq_pc", 64'(deq_pc), 64'h404);
      step("drain", 0, 1, 0, 32'h0, 32'h0);

      // Drop counter saturation: 2 per round, 0 -> 14 -> saturates at 15.
      do_reset();
      for (int r = 0; r < 9; r++) begin
         for (int k = 0; k < 4; k++)
            step("sat_fill", 1, 0, 0, 32'h800 + 32'(16 * r + 4 * k), 32'(r));
         step("sat_flush", 0, 1, 1, 32'h0, 32'h0);
         step("sat_drain", 0, 1, 0, 32'h0, 32'h0);
         if (r == 6) check("sat.below", 64'(drop_cnt), 64'd14);
         if (r == 7) check("sat.reach", 64'(drop_cnt), 64'(SAT));
      end
      check("sat.hold", 64'(drop_cnt), 64'(SAT));

      // Randomised traffic against the reference model, with a mid-stream reset.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            do_reset();
            check("midreset.count", 64'(count), 64'd0);
            check("midreset.deq_valid", 64'(deq_valid), 64'd0);
         end
         ev = ($urandom_range(3) != 0);
         dr = ($urandom_range(2) != 0);
         fl = dr && (mq.size() > 0) && ($urandom_range(7) == 0);
         step("rand", ev, dr, fl, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
